// File: rtl/arm_pipelined_cond_exec_stage.sv
// Decode->Execute register, NZCV flags and ARM condition evaluation with write/branch gating.
// Optional squash counter enabled by defining ARM_COND_SQUASH_CNT_EN.
module arm_pipelined_cond_exec_stage #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_Stall_Execute,
    input  logic             i_Flush_Execute,
    input  logic [3:0]       i_Cond_Decode,
    input  logic [1:0]       i_Flag_Write_Decode,
    input  logic             i_PC_Src_Decode,
    input  logic             i_Reg_Write_Decode,
    input  logic             i_Mem_Write_Decode,
    input  logic             i_Mem_To_Reg_Decode,
    input  logic             i_ALU_Src_Decode,
    input  logic             i_No_Write_Decode,
    input  logic [1:0]       i_ALU_Control_Decode,
    input  logic [3:0]       i_ALU_Flags,
    output logic [3:0]       o_Flags,
    output logic             o_Cond_Ex,
    output logic             o_PC_Src_Execute,
    output logic             o_Reg_Write_Execute,
    output logic             o_Mem_Write_Execute,
    output logic             o_Mem_To_Reg_Execute,
    output logic             o_ALU_Src_Execute,
    output logic [1:0]       o_ALU_Control_Execute,
    output logic [CNT_W-1:0] o_Squash_Count
);

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flag_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       no_write;
        logic [1:0] alu_control;
    } ex_ctrl_t;

    // A bubble carries "always" as its condition so it never looks like a squashed instruction.
    localparam ex_ctrl_t BUBBLE = '{cond: 4'hE, flag_write: 2'b00, pc_src: 1'b0, reg_write: 1'b0,
                                    mem_write: 1'b0, mem_to_reg: 1'b0, alu_src: 1'b0,
                                    no_write: 1'b0, alu_control: 2'b00};

    ex_ctrl_t   ex_q, ex_d, dec_in;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       n, z, c, v;

    assign dec_in = '{cond: i_Cond_Decode, flag_write: i_Flag_Write_Decode,
                      pc_src: i_PC_Src_Decode, reg_write: i_Reg_Write_Decode,
                      mem_write: i_Mem_Write_Decode, mem_to_reg: i_Mem_To_Reg_Decode,
                      alu_src: i_ALU_Src_Decode, no_write: i_No_Write_Decode,
                      alu_control: i_ALU_Control_Decode};

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_ex = 1'b1;
        case (ex_q.cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = !z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = !c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = !n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = !v;
            4'h8: cond_ex = c && !z;
            4'h9: cond_ex = !c || z;
            4'hA: cond_ex = (n == v);
            4'hB: cond_ex = (n != v);
            4'hC: cond_ex = !z && (n == v);
            4'hD: cond_ex = z || (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    // NOTE: every variable gets a default first so no path through always_comb infers a latch.
    always_comb begin
        ex_d = ex_q;
        if (i_Flush_Execute) begin
            ex_d = BUBBLE;
        end else if (!i_Stall_Execute) begin
            ex_d = dec_in;
        end
    end

    // Flag writeback belongs to the instruction already in Execute, so flush does not block it.
    always_comb begin
        flags_d = flags_q;
        if (!i_Stall_Execute && cond_ex) begin
            if (ex_q.flag_write[1]) flags_d[3:2] = i_ALU_Flags[3:2];
            if (ex_q.flag_write[0]) flags_d[1:0] = i_ALU_Flags[1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            ex_q    <= BUBBLE;
            flags_q <= RESET_FLAGS;
        end else begin
            ex_q    <= ex_d;
            flags_q <= flags_d;
        end
    end

`ifdef ARM_COND_SQUASH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_valid;

    assign ex_valid = ex_q.pc_src || ex_q.reg_write || ex_q.mem_write || (ex_q.flag_write != 2'b00);

    always_comb begin
        cnt_d = cnt_q;
        if (!i_Stall_Execute && ex_valid && !cond_ex) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_Squash_Count = cnt_q;
`else
    assign o_Squash_Count = '0;
`endif

    assign o_Flags               = flags_q;
    assign o_Cond_Ex             = cond_ex;
    assign o_PC_Src_Execute      = ex_q.pc_src && cond_ex;
    assign o_Reg_Write_Execute   = ex_q.reg_write && cond_ex && !ex_q.no_write;
    assign o_Mem_Write_Execute   = ex_q.mem_write && cond_ex;
    assign o_Mem_To_Reg_Execute  = ex_q.mem_to_reg;
    assign o_ALU_Src_Execute     = ex_q.alu_src;
    assign o_ALU_Control_Execute = ex_q.alu_control;

endmodule

// File: tb/tb_arm_pipelined_cond_exec_stage.sv
// Self-checking bench: directed vector table followed by randomized traffic against a reference model.
module tb_arm_pipelined_cond_exec_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, stall, flush;
    logic [3:0]       cond;
    logic [1:0]       fw;
    logic             pc, rw, mw, m2r, asrc, nw;
    logic [1:0]       aluc;
    logic [3:0]       aluf;
    logic [3:0]       flags_o;
    logic             cex_o, pc_o, rw_o, mw_o, m2r_o, as_o;
    logic [1:0]       aluc_o;
    logic [CNT_W-1:0] cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arm_pipelined_cond_exec_stage #(.RESET_FLAGS(4'b0000), .CNT_W(CNT_W)) dut (
        .i_CLK(clk), .i_RST(rst), .i_Stall_Execute(stall), .i_Flush_Execute(flush),
        .i_Cond_Decode(cond), .i_Flag_Write_Decode(fw), .i_PC_Src_Decode(pc),
        .i_Reg_Write_Decode(rw), .i_Mem_Write_Decode(mw), .i_Mem_To_Reg_Decode(m2r),
        .i_ALU_Src_Decode(asrc), .i_No_Write_Decode(nw), .i_ALU_Control_Decode(aluc),
        .i_ALU_Flags(aluf), .o_Flags(flags_o), .o_Cond_Ex(cex_o), .o_PC_Src_Execute(pc_o),
        .o_Reg_Write_Execute(rw_o), .o_Mem_Write_Execute(mw_o), .o_Mem_To_Reg_Execute(m2r_o),
        .o_ALU_Src_Execute(as_o), .o_ALU_Control_Execute(aluc_o), .o_Squash_Count(cnt_o)
    );

    typedef struct {
        logic       rst, stall, flush;
        logic [3:0] cond;
        logic [1:0] fw;
        logic       pc, rw, mw, m2r, asrc, nw;
        logic [1:0] aluc;
        logic [3:0] aluf;
        logic [3:0] e_flags;
        logic       e_cex;
        logic [6:0] e_ctrl;   // {pc, rw, mw, m2r, alu_src, alu_control}
        int         e_cnt;
    } vec_t;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] fw;
        logic       pc, rw, mw, m2r, asrc, nw;
        logic [1:0] aluc;
    } instr_t;

    vec_t   vecs[$];
    instr_t m_e;
    logic [3:0] m_flags;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic r, s, f, input logic [3:0] cd, input logic [1:0] fwv,
                           input logic p, w, m, mr, a, nwv, input logic [1:0] ac,
                           input logic [3:0] af, input logic [3:0] ef, input logic ec,
                           input logic [6:0] ectl, input int ecnt);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.cond = cd; t.fw = fwv;
        t.pc = p; t.rw = w; t.mw = m; t.m2r = mr; t.asrc = a; t.nw = nwv;
        t.aluc = ac; t.aluf = af; t.e_flags = ef; t.e_cex = ec; t.e_ctrl = ectl; t.e_cnt = ecnt;
        vecs.push_back(t);
    endtask

    // Conditions come in pairs: even code tests a predicate, odd code tests its negation.
    function automatic logic cond_pass(input logic [3:0] cd, input logic [3:0] f);
        logic nn, zz, cc, vv, base;
        {nn, zz, cc, vv} = f;
        if (cd >= 4'hE) return 1'b1;
        case (cd[3:1])
            3'd0: base = zz;
            3'd1: base = cc;
            3'd2: base = nn;
            3'd3: base = vv;
            3'd4: base = cc & ~zz;
            3'd5: base = (nn == vv);
            default: base = ~zz & (nn == vv);
        endcase
        return cd[0] ? ~base : base;
    endfunction

    task automatic drive(input logic r, s, f, input logic [3:0] cd, input logic [1:0] fwv,
                         input logic p, w, m, mr, a, nwv, input logic [1:0] ac, input logic [3:0] af);
        rst = r; stall = s; flush = f; cond = cd; fw = fwv; pc = p; rw = w; mw = m;
        m2r = mr; asrc = a; nw = nwv; aluc = ac; aluf = af;
    endtask

    // Reference model: advance one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic pass;
        instr_t bubble;
        bubble = '{cond: 4'hE, fw: 2'b00, pc: 1'b0, rw: 1'b0, mw: 1'b0, m2r: 1'b0,
                   asrc: 1'b0, nw: 1'b0, aluc: 2'b00};
        if (rst) begin
            m_e = bubble; m_flags = 4'b0000; m_cnt = 0;
        end else begin
            pass = cond_pass(m_e.cond, m_flags);
            if (!stall) begin
                if (pass && m_e.fw[1]) m_flags[3:2] = aluf[3:2];
                if (pass && m_e.fw[0]) m_flags[1:0] = aluf[1:0];
                if (!pass && (m_e.pc || m_e.rw || m_e.mw || m_e.fw != 2'b00))
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
            if (flush) m_e = bubble;
            else if (!stall)
                m_e = '{cond: cond, fw: fw, pc: pc, rw: rw, mw: mw, m2r: m2r, asrc: asrc,
                        nw: nw, aluc: aluc};
        end
    endtask

    function automatic int cnt_expect(input int c);
`ifdef ARM_COND_SQUASH_CNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    initial begin
        logic       p;
        logic [6:0] ectl;
        drive(1, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //      rst s f cond fw pc rw mw m2r as nw aluc aluf | flags cex ctrl        cnt
        add_vec(1, 0, 0, 4'h3, 3, 1, 1, 1, 1, 1, 0, 3, 4'hF, 4'h0, 1, 7'b0000000, 0);
        add_vec(1, 0, 0, 4'h3, 3, 1, 1, 1, 1, 1, 0, 3, 4'hF, 4'h0, 1, 7'b0000000, 0);
        add_vec(0, 0, 0, 4'hE, 3, 0, 0, 0, 0, 0, 0, 0, 4'h4, 4'h0, 1, 7'b0000000, 0);
        add_vec(0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h4, 4'h4, 1, 7'b0100000, 0);
        add_vec(0, 0, 0, 4'h1, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h4, 0, 7'b0000000, 0);
        add_vec(0, 0, 0, 4'h1, 3, 0, 0, 0, 0, 0, 0, 0, 4'h8, 4'h4, 0, 7'b0000000, 1);
        add_vec(0, 0, 0, 4'hE, 2, 0, 1, 0, 0, 0, 1, 0, 4'h8, 4'h4, 1, 7'b0000000, 2);
        add_vec(0, 0, 0, 4'hE, 0, 1, 0, 1, 0, 0, 0, 0, 4'h8, 4'h8, 1, 7'b1010000, 2);
        add_vec(0, 0, 0, 4'hC, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h8, 0, 7'b0000000, 2);
        add_vec(0, 0, 0, 4'hB, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h8, 1, 7'b1000000, 3);
        add_vec(0, 1, 1, 4'h0, 0, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h8, 1, 7'b0000000, 3);
        add_vec(0, 0, 0, 4'hE, 1, 0, 1, 1, 1, 1, 0, 2, 4'h3, 4'h8, 1, 7'b0111110, 3);
        for (int i = 0; i < 3; i++)
            add_vec(0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1, 4'h3, 4'h8, 1, 7'b0111110, 3);
        add_vec(0, 0, 0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 4'h3, 4'hB, 1, 7'b0000000, 3);
        add_vec(0, 0, 0, 4'hE, 3, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'hB, 1, 7'b0000000, 3);
        add_vec(0, 0, 1, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h4, 4'h4, 1, 7'b0000000, 3);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].cond, vecs[i].fw,
                  vecs[i].pc, vecs[i].rw, vecs[i].mw, vecs[i].m2r, vecs[i].asrc, vecs[i].nw,
                  vecs[i].aluc, vecs[i].aluf);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d flags", i), 32'(flags_o), 32'(vecs[i].e_flags));
            check($sformatf("vec%0d cond_ex", i), 32'(cex_o), 32'(vecs[i].e_cex));
            check($sformatf("vec%0d ctrl", i), 32'({pc_o, rw_o, mw_o, m2r_o, as_o, aluc_o}),
                  32'(vecs[i].e_ctrl));
            check($sformatf("vec%0d squash_cnt", i), 32'(cnt_o), 32'(cnt_expect(vecs[i].e_cnt)));
        end

        for (int k = 0; k < 600; k++) begin
            drive((k == 0) || ($urandom_range(0, 99) < 2), $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10, 4'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), 4'($urandom));
            model_edge();
            @(posedge clk);
            #1;
            p = cond_pass(m_e.cond, m_flags);
            ectl = {m_e.pc & p, m_e.rw & p & ~m_e.nw, m_e.mw & p, m_e.m2r, m_e.asrc, m_e.aluc};
            check($sformatf("rnd%0d flags", k), 32'(flags_o), 32'(m_flags));
            check($sformatf("rnd%0d cond_ex", k), 32'(cex_o), 32'(p));
            check($sformatf("rnd%0d ctrl", k), 32'({pc_o, rw_o, mw_o, m2r_o, as_o, aluc_o}),
                  32'(ectl));
            check($sformatf("rnd%0d squash_cnt", k), 32'(cnt_o), 32'(cnt_expect(m_cnt)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
